// File: rtl/fifo_ctrl.sv
// FWFT FIFO pointer/flag controller for a dual-port RAM with a synchronous write
// port and an asynchronous read port.
module fifo_ctrl #(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 2 ** ADDRESS_WIDTH,
  parameter int AFULL_LEVEL   = DEPTH - 4,
  parameter int AEMPTY_LEVEL  = 4
) (
  input  logic                     fifoctrl_clk_i,
  input  logic                     fifoctrl_rstn_i,
  input  logic                     fifoctrl_flush_i,
  input  logic                     fifoctrl_push_i,
  input  logic [DATA_WIDTH-1:0]    fifoctrl_wdata_i,
  input  logic                     fifoctrl_pop_i,
  output logic [DATA_WIDTH-1:0]    fifoctrl_rdata_o,
  output logic                     fifoctrl_full_o,
  output logic                     fifoctrl_empty_o,
  output logic                     fifoctrl_afull_o,
  output logic                     fifoctrl_aempty_o,
  output logic [ADDRESS_WIDTH:0]   fifoctrl_count_o,
  output logic                     fifoctrl_overflow_o,
  output logic                     fifoctrl_underflow_o,
  output logic                     fifoctrl_ram_we_o,
  output logic [ADDRESS_WIDTH-1:0] fifoctrl_ram_waddr_o,
  output logic [ADDRESS_WIDTH-1:0] fifoctrl_ram_raddr_o,
  output logic [DATA_WIDTH-1:0]    fifoctrl_ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]    fifoctrl_ram_rdata_i
);

  localparam int AW = ADDRESS_WIDTH;
  localparam int CW = ADDRESS_WIDTH + 1;

  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic full_s;
  logic empty_s;
  logic push_ok_s;
  logic pop_ok_s;

  // Status flags and accepted-request qualifiers from the current occupancy.
  always_comb begin
    full_s    = (count_q == CW'(DEPTH));
    empty_s   = (count_q == {CW{1'b0}});
    push_ok_s = fifoctrl_push_i & ~full_s;
    pop_ok_s  = fifoctrl_pop_i & ~empty_s;
  end

  // Next-state computation; flush wins over any request in the same cycle.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (fifoctrl_flush_i) begin
      wr_ptr_d    = {CW{1'b0}};
      rd_ptr_d    = {CW{1'b0}};
      count_d     = {CW{1'b0}};
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_d = wr_ptr_q + CW'(1'b1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
        rd_ptr_d = rd_ptr_q + CW'(1'b1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_d = count_q + CW'(1'b1);
        2'b01:   count_d = count_q - CW'(1'b1);
        default: count_d = count_q;
      endcase
      if (fifoctrl_push_i & full_s) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end
      if (fifoctrl_pop_i & empty_s) begin
        underflow_d = 1'b1;
      end else begin
        underflow_d = underflow_q;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge fifoctrl_clk_i) begin
    if (!fifoctrl_rstn_i) begin
      wr_ptr_q    <= {CW{1'b0}};
      rd_ptr_q    <= {CW{1'b0}};
      count_q     <= {CW{1'b0}};
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Output mapping; the RAM write is suppressed while reset or flush is pending.
  always_comb begin
    fifoctrl_full_o      = full_s;
    fifoctrl_empty_o     = empty_s;
    fifoctrl_afull_o     = (count_q >= CW'(AFULL_LEVEL));
    fifoctrl_aempty_o    = (count_q <= CW'(AEMPTY_LEVEL));
    fifoctrl_count_o     = count_q;
    fifoctrl_overflow_o  = overflow_q;
    fifoctrl_underflow_o = underflow_q;
    fifoctrl_ram_we_o    = push_ok_s & ~fifoctrl_flush_i & fifoctrl_rstn_i;
    fifoctrl_ram_waddr_o = wr_ptr_q[AW-1:0];
    fifoctrl_ram_raddr_o = rd_ptr_q[AW-1:0];
    fifoctrl_ram_wdata_o = fifoctrl_wdata_i;
    fifoctrl_rdata_o     = fifoctrl_ram_rdata_i;
  end

  fifo_ctrl_chk #(
    .CW    (CW),
    .DEPTH (DEPTH)
  ) u_chk (
    .clk_i    (fifoctrl_clk_i),
    .rstn_i   (fifoctrl_rstn_i),
    .wr_ptr_i (wr_ptr_q),
    .rd_ptr_i (rd_ptr_q),
    .count_i  (count_q)
  );

endmodule

// Occupancy/pointer consistency checks for fifo_ctrl.
module fifo_ctrl_chk #(
  parameter int CW    = 7,
  parameter int DEPTH = 64
) (
  input logic          clk_i,
  input logic          rstn_i,
  input logic [CW-1:0] wr_ptr_i,
  input logic [CW-1:0] rd_ptr_i,
  input logic [CW-1:0] count_i
);

  logic [CW-1:0] diff_s;

  // Pointer distance modulo 2*DEPTH falls out of CW-bit subtraction.
  always_comb begin
    diff_s = wr_ptr_i - rd_ptr_i;
  end

  a_count_matches_ptrs: assert property (@(posedge clk_i) disable iff (!rstn_i)
    count_i == diff_s);

  a_count_in_range: assert property (@(posedge clk_i) disable iff (!rstn_i)
    count_i <= CW'(DEPTH));

endmodule
